lab1_imul_int_mul_param: RTL and testbench
==========================================

LAB1_IMUL_INT_MUL_PARAM -- requirements
Module: lab1_imul_int_mul_param

Interface
REQ-001 SHALL have parameter: nbits, 32, operand width in bits (legal range 4..64).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: istream_val  input  1  request valid.
REQ-005 SHALL have port: istream_rdy  output  1  request ready.
REQ-006 SHALL have port: istream_msg  input  2*nbits  operand a in [2*nbits-1:nbits], operand b in [nbits-1:0].
REQ-007 SHALL have port: istream_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with istream_msg.
REQ-008 SHALL have port: ostream_val  output  1  response valid.
REQ-009 SHALL have port: ostream_rdy  input  1  response ready.
REQ-010 SHALL have port: ostream_msg  output  2*nbits  full-width product.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 IDLE: istream_rdy=1, ostream_val=0; a request is accepted when istream_val & istream_rdy; next state CALC.
REQ-013 On acceptance SHALL capture |a| and |b| (magnitudes when istream_signed=1, raw when 0), the result sign (sign(a) XOR sign(b), 0 if unsigned), and clear the 2*nbits accumulator.
REQ-014 CALC: istream_rdy=0, ostream_val=0; shift-and-add with a zero-extended to 2*nbits; accumulator arithmetic modulo 2^(2*nbits).
REQ-015 Number of CALC cycles k is set by the configuration (REQ-024/REQ-025); after the k-th CALC cycle the next state is DONE.
REQ-016 On entry to DONE, ostream_msg SHALL equal the accumulator, two's-complement negated in 2*nbits when the result sign is 1.
REQ-017 DONE: ostream_val=1, istream_rdy=0; ostream_msg held stable while ostream_val=1 and ostream_rdy=0; on ostream_rdy=1 go to IDLE.
REQ-018 ostream_val SHALL first assert exactly k+1 cycles after the acceptance cycle.
REQ-019 Requests never overlap: a new request is accepted no earlier than the cycle after the DONE handshake.
REQ-020 Most-negative operands SHALL be handled exactly: (-2^(nbits-1))*(-2^(nbits-1)) = 2^(2*nbits-2).
REQ-021 Any operand equal to 0 SHALL produce product 0 with correct latency; a negative sign with a zero product SHALL yield 0.

Reset
REQ-022 While reset=1, independent of clk: state=IDLE, accumulator and operand registers=0, istream_rdy=0, ostream_val=0, ostream_msg=0.
REQ-023 Reset asserted mid-CALC or mid-DONE SHALL abort the operation; no response is produced; istream_rdy=1 from the first rising edge after deassertion.

Configuration
REQ-024 With LAB1_IMUL_ZERO_SKIP_EN defined: each CALC cycle adds (|a| << tz(b_rem)) to the accumulator and clears the lowest set bit of b_rem (tz = trailing-zero count); k = max(1, popcount(|b|)).
REQ-025 Without LAB1_IMUL_ZERO_SKIP_EN: each CALC cycle adds a_rem when b_rem[0]=1, then a_rem<<=1, b_rem>>=1; k = nbits for every request.
REQ-026 Product values SHALL be identical in both configurations; only latency differs.

Verification
REQ-027 nbits=32, unsigned, a=3, b=5, ostream_rdy=1 -> ostream_msg=15; ostream_val at cycle +3 with skip, +33 without.
REQ-028 nbits=32, signed, a=-7 (0xFFFFFFF9), b=6 -> ostream_msg=0xFFFFFFFFFFFFFFD6 (-42); signed a=0x80000000, b=0x80000000 -> 0x4000000000000000.
REQ-029 nbits=32, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE00000001; with skip k=32 (latency 33); a=5, b=0 -> 0 at latency 2 with skip.
REQ-030 nbits=8, unsigned a=0x80, b=0x02 -> 0x0100; hold ostream_rdy=0 10 cycles -> ostream_val and ostream_msg stable, istream_rdy=0, istream_val ignored.
REQ-031 Assert reset 2 cycles into CALC, deassert, then send a=2, b=9 -> no stale response, ostream_msg=18.
REQ-032 Randomised back-to-back stream (200 requests, random signed mode, random ostream_rdy) -> every product matches reference model, in order, none dropped or duplicated.

Source files
------------

// File: rtl/lab1_imul_int_mul_param.sv
// Iterative integer multiplier with valid/ready request and response streams.
// The operands are converted to magnitudes and multiplied by shift-and-add.
// The product sign is applied when the result is written to the output.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   istream_val/rdy/msg  request stream; msg = {a, b}, each nbits wide
//   istream_signed       1 = two's-complement operands, sampled with msg
//   ostream_val/rdy/msg  response stream; msg = 2*nbits product
//
// Optional feature: define LAB1_IMUL_ZERO_SKIP_EN to process only the set
// bits of |b|, one set bit per cycle. The latency is then
// max(1, popcount(|b|)) + 1 instead of nbits + 1.
module lab1_imul_int_mul_param #(
    parameter int unsigned nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [2*nbits-1:0] istream_msg,
    input  logic               istream_signed,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [2*nbits-1:0] ostream_msg
);

    localparam int unsigned W2 = 2 * nbits;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    a_rem;
    logic [nbits-1:0] b_rem;
    logic             neg;

    logic [nbits-1:0] op_a;
    logic [nbits-1:0] op_b;
    logic [nbits-1:0] mag_a;
    logic [nbits-1:0] mag_b;
    logic [W2-1:0]    addend;
    logic [W2-1:0]    acc_next;
    logic [W2-1:0]    a_next;
    logic [nbits-1:0] b_next;
    logic [W2-1:0]    prod;
    logic             last;

`ifdef LAB1_IMUL_ZERO_SKIP_EN
    localparam int unsigned TZW = $clog2(nbits);
    logic [TZW-1:0] tz;
`else
    localparam int unsigned CW = $clog2(nbits + 1);
    logic [CW-1:0] count;
`endif

    assign op_a  = istream_msg[W2-1:nbits];
    assign op_b  = istream_msg[nbits-1:0];
    // The most-negative value negates to 2^(nbits-1) when read as unsigned.
    assign mag_a = (istream_signed && op_a[nbits-1]) ? (~op_a + nbits'(1)) : op_a;
    assign mag_b = (istream_signed && op_b[nbits-1]) ? (~op_b + nbits'(1)) : op_b;

    // One shift-and-add step, plus the signed result if this is the last step.
    always_comb begin
        addend = '0;
        a_next = a_rem;
        b_next = b_rem;
        last   = 1'b0;
`ifdef LAB1_IMUL_ZERO_SKIP_EN
        tz = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (b_rem[i]) tz = TZW'(i);
        end
        if (b_rem != '0) addend = a_rem << tz;
        b_next = b_rem & (b_rem - nbits'(1));
        last   = (b_next == '0);
`else
        if (b_rem[0]) addend = a_rem;
        a_next = a_rem << 1;
        b_next = b_rem >> 1;
        last   = (count == CW'(nbits - 1));
`endif
        acc_next = acc + addend;
        prod     = neg ? (~acc_next + W2'(1)) : acc_next;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            a_rem       <= '0;
            b_rem       <= '0;
            neg         <= 1'b0;
            istream_rdy <= 1'b0;
            ostream_val <= 1'b0;
            ostream_msg <= '0;
`ifndef LAB1_IMUL_ZERO_SKIP_EN
            count       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    istream_rdy <= 1'b1;
                    ostream_val <= 1'b0;
                    if (istream_val && istream_rdy) begin
                        a_rem       <= W2'(mag_a);
                        b_rem       <= mag_b;
                        neg         <= istream_signed & (op_a[nbits-1] ^ op_b[nbits-1]);
                        acc         <= '0;
                        istream_rdy <= 1'b0;
                        state       <= CALC;
`ifndef LAB1_IMUL_ZERO_SKIP_EN
                        count       <= '0;
`endif
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    a_rem <= a_next;
                    b_rem <= b_next;
`ifndef LAB1_IMUL_ZERO_SKIP_EN
                    count <= count + CW'(1);
`endif
                    if (last) begin
                        ostream_val <= 1'b1;
                        ostream_msg <= prod;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (ostream_rdy) begin
                        ostream_val <= 1'b0;
                        istream_rdy <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab1_imul_int_mul_param.sv
// Bench for lab1_imul_int_mul_param. A 32-bit instance is checked on every
// cycle against an arithmetic reference. A second 8-bit instance is used for
// the output back-pressure hold case.
module tb_lab1_imul_int_mul_param;

    localparam int unsigned N = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_val;
    logic          in_rdy;
    logic [63:0]   in_msg;
    logic          in_signed;
    logic          out_val;
    logic          out_rdy;
    logic [63:0]   out_msg;

    logic          v8;
    logic          r8;
    logic [15:0]   m8;
    logic          s8;
    logic          ov8;
    logic          or8;
    logic [15:0]   om8;

    always #5 clk = ~clk;

    lab1_imul_int_mul_param #(.nbits(N)) dut (
        .clk(clk), .reset(reset),
        .istream_val(in_val), .istream_rdy(in_rdy), .istream_msg(in_msg),
        .istream_signed(in_signed),
        .ostream_val(out_val), .ostream_rdy(out_rdy), .ostream_msg(out_msg)
    );

    lab1_imul_int_mul_param #(.nbits(8)) dut8 (
        .clk(clk), .reset(reset),
        .istream_val(v8), .istream_rdy(r8), .istream_msg(m8),
        .istream_signed(s8),
        .ostream_val(ov8), .ostream_rdy(or8), .ostream_msg(om8)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product: sign- or zero-extend both operands, multiply mod 2^64.
    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Reference latency from acceptance to the first ostream_val.
    function automatic int model_lat(input logic [31:0] b, input logic s);
`ifdef LAB1_IMUL_ZERO_SKIP_EN
        logic [31:0] m;
        int p;
        m = (s && b[31]) ? (~b + 32'd1) : b;
        p = $countones(m);
        return ((p == 0) ? 1 : p) + 1;
`else
        if (s && b[31]) return N + 1;
        return N + 1;
`endif
    endfunction

    typedef struct {
        logic [63:0] prod;
        int          lat;
        int          start;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          cyc = 0;
    int          resp_cnt = 0;
    int          first_lat = 0;
    logic        prev_val = 1'b0;
    logic [63:0] prev_msg = '0;
    logic [63:0] last_prod = '0;
    int          last_lat = 0;

    // Compare process: scoreboard of accepted requests against every output cycle.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            prev_val = 1'b0;
        end else begin
            if (in_val && in_rdy) begin
                e.prod  = model_prod(in_msg[63:32], in_msg[31:0], in_signed);
                e.lat   = model_lat(in_msg[31:0], in_signed);
                e.start = cyc;
                q.push_back(e);
            end
            check("spurious_val", 64'(out_val && (q.size() == 0)), 64'(0));
            if (out_val && q.size() != 0) begin
                check("rdy_low_in_done", 64'(in_rdy), 64'(0));
                check("prod", out_msg, q[0].prod);
                if (!prev_val) begin
                    first_lat = cyc - q[0].start;
                    check("latency", 64'(first_lat), 64'(q[0].lat));
                end else begin
                    check("hold", out_msg, prev_msg);
                end
                if (out_rdy) begin
                    last_prod = out_msg;
                    last_lat  = first_lat;
                    resp_cnt++;
                    void'(q.pop_front());
                end
            end
            prev_val = out_val;
            prev_msg = out_msg;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_val    = 1'b1;
        in_msg    = {a, b};
        in_signed = s;
        @(negedge clk);
        while (!in_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) check("accept_timeout", 64'(in_rdy), 64'(1));
        @(posedge clk);
        #1;
        in_val = 1'b0;
    endtask

    task automatic txn(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp_p,
                       input int lat_skip, input int lat_full);
        int start;
        int n;
        start = resp_cnt;
        n = 0;
        send(a, b, s);
        while (resp_cnt == start && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 64'(resp_cnt - start), 64'(1));
        check(name, last_prod, exp_p);
`ifdef LAB1_IMUL_ZERO_SKIP_EN
        check({name, "_lat"}, 64'(last_lat), 64'(lat_skip));
`else
        check({name, "_lat"}, 64'(last_lat), 64'(lat_full));
`endif
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    logic rnd_en;
    int   start_cnt;
    int   n;

    initial begin
        reset     = 1'b1;
        in_val    = 1'b0;
        in_msg    = '0;
        in_signed = 1'b0;
        out_rdy   = 1'b1;
        v8        = 1'b0;
        m8        = '0;
        s8        = 1'b0;
        or8       = 1'b1;
        rnd_en    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_rdy", 64'(in_rdy), 64'(0));
        check("rst_val", 64'(out_val), 64'(0));
        check("rst_msg", out_msg, 64'(0));
        check("rst_rdy8", 64'(r8), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 64'(in_rdy), 64'(1));
        check("post_rst_rdy8", 64'(r8), 64'(1));

        txn("u3x5",     32'd3,          32'd5,          1'b0, 64'd15,                 3,  33);
        txn("sm7x6",    32'hFFFF_FFF9,  32'd6,          1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 3,  33);
        txn("smin2",    32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000, 2,  33);
        txn("umax2",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, 33, 33);
        txn("u5x0",     32'd5,          32'd0,          1'b0, 64'd0,                  2,  33);
        txn("sneg_x0",  32'hFFFF_FFFF,  32'd0,          1'b1, 64'd0,                  2,  33);
        txn("s0x7",     32'd0,          32'd7,          1'b1, 64'd0,                  4,  33);

        // Abort a calculation with reset; the aborted request must never answer.
        send(32'd100, 32'd7, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_rdy", 64'(in_rdy), 64'(0));
        check("mid_rst_val", 64'(out_val), 64'(0));
        check("mid_rst_msg", out_msg, 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_rdy", 64'(in_rdy), 64'(1));
        txn("after_rst", 32'd2, 32'd9, 1'b0, 64'd18, 3, 33);

        // 8-bit instance: back-pressure hold while a new request waits.
        @(posedge clk);
        #1;
        or8 = 1'b0;
        v8  = 1'b1;
        m8  = {8'h80, 8'h02};
        n   = 0;
        @(negedge clk);
        while (!r8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        m8 = {8'h03, 8'h04};
        n  = 0;
        @(negedge clk);
        while (!ov8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w8_val", 64'(ov8), 64'(1));
        check("w8_prod", 64'(om8), 64'h0100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("w8_hold_val", 64'(ov8), 64'(1));
            check("w8_hold_msg", 64'(om8), 64'h0100);
            check("w8_hold_rdy", 64'(r8), 64'(0));
        end
        @(posedge clk);
        #1;
        or8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("w8_released", 64'(ov8), 64'(0));
        n = 0;
        while (!ov8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w8_next_prod", 64'(om8), 64'h000C);
        v8 = 1'b0;

        // Back-to-back random stream with random response back-pressure.
        start_cnt = resp_cnt;
        rnd_en    = 1'b1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send(pick(), pick(), 1'($urandom_range(0, 1)));
                end
                rnd_en = 1'b0;
            end
            begin
                while (rnd_en) begin
                    @(posedge clk);
                    #1;
                    out_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(q.size()), 64'(0));
        check("rand_count", 64'(resp_cnt - start_cnt), 64'(200));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
